// File: rtl/can_mac_tx_framer_if.sv
// ---------------------------------------------------------------------------
// can_mac_tx_framer_if
// Bit-stream link between the CAN TX framer and the downstream bit stuffer.
//   bit_out         : unstuffed frame bit offered to the stuffer
//   valid           : bit_out is valid
//   ready           : stuffer accepts bit_out (a bit moves on valid && ready)
//   stuffing_enable : stuffing window (SOF through the post-CRC flush)
// Modports: master = framer side, slave = stuffer side.
// ---------------------------------------------------------------------------
interface can_mac_tx_framer_if;
    logic bit_out;
    logic valid;
    logic ready;
    logic stuffing_enable;

    modport master (
        output bit_out,
        output valid,
        output stuffing_enable,
        input  ready
    );

    modport slave (
        input  bit_out,
        input  valid,
        input  stuffing_enable,
        output ready
    );
endinterface

// File: rtl/can_mac_tx_framer.sv
// ---------------------------------------------------------------------------
// can_mac_tx_framer
// Serialises a CAN 2.0A standard frame (SOF .. IFS) into unstuffed bits for
// a downstream bit stuffer, computing CRC-15 on the fly.
// Ports:
//   clk, reset        : clock, asynchronous active-high reset
//   tx_req            : frame request, sampled only in IDLE
//   tx_id/rtr/dlc/data: frame contents, latched on accept (byte 0 = [63:56])
//   tx_abort          : drop the current frame back to IDLE, no tx_done
//   tx_busy           : high in every non-IDLE state
//   tx_done           : one-cycle pulse when the last IFS bit has gone
//   bs (master)       : bit_out / valid / ready / stuffing_enable stream
// ---------------------------------------------------------------------------
module can_mac_tx_framer (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_req,
    input  logic [10:0]         tx_id,
    input  logic                tx_rtr,
    input  logic [3:0]          tx_dlc,
    input  logic [63:0]         tx_data,
    input  logic                tx_abort,
    output logic                tx_busy,
    output logic                tx_done,
    can_mac_tx_framer_if.master bs
);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        SOF         = 4'd1,
        ID          = 4'd2,
        RTR         = 4'd3,
        IDE         = 4'd4,
        R0          = 4'd5,
        DLC         = 4'd6,
        DATA        = 4'd7,
        CRC         = 4'd8,
        STUFF_FLUSH = 4'd9,
        CRC_DELIM   = 4'd10,
        ACK_SLOT    = 4'd11,
        ACK_DELIM   = 4'd12,
        EOF         = 4'd13,
        IFS         = 4'd14
    } state_t;

    state_t      state_r;
    logic [6:0]  cnt_r;          // bit index within the current field (0..63)
    logic [14:0] crc_r;
    logic [10:0] id_r;
    logic        rtr_r;
    logic [3:0]  dlc_r;
    logic [63:0] data_r;
    logic        bit_out_r;
    logic        valid_r;
    logic        stuff_en_r;
    logic        busy_r;
    logic        done_r;

    logic        xfer_s;
    logic [6:0]  data_len_s;
    logic [6:0]  last_idx_s;
    state_t      follow_s;
    state_t      nxt_state_s;
    logic [6:0]  nxt_cnt_s;
    logic [14:0] crc_nxt_s;
    logic        nxt_bit_s;

    // CRC-15/CAN single-bit update.
    function automatic logic [14:0] crc15_step_f(input logic [14:0] crc, input logic b);
        logic nxt;
        nxt = b ^ crc[14];
        crc15_step_f = {crc[13:0], 1'b0} ^ (nxt ? 15'h4599 : 15'h0000);
    endfunction

    // Fields covered by the CRC.
    function automatic logic crc_zone_f(input state_t st);
        case (st)
            SOF, ID, RTR, IDE, R0, DLC, DATA: crc_zone_f = 1'b1;
            default:                          crc_zone_f = 1'b0;
        endcase
    endfunction

    // Fields during which the stuffer may insert stuff bits.
    function automatic logic stuff_window_f(input state_t st);
        case (st)
            SOF, ID, RTR, IDE, R0, DLC, DATA, CRC, STUFF_FLUSH: stuff_window_f = 1'b1;
            default:                                          stuff_window_f = 1'b0;
        endcase
    endfunction

    // Bit value at position cnt of field st; all trailing fields are recessive.
    function automatic logic field_bit_f(input state_t      st,
                                         input logic [5:0]  cnt,
                                         input logic [14:0] crc,
                                         input logic [10:0] id,
                                         input logic        rtr,
                                         input logic [3:0]  dlc,
                                         input logic [63:0] data);
        logic [3:0] id_idx;
        logic [1:0] dlc_idx;
        logic [5:0] data_idx;
        logic [3:0] crc_idx;
        id_idx   = 4'd10 - cnt[3:0];
        dlc_idx  = 2'd3 - cnt[1:0];
        data_idx = 6'd63 - cnt;
        crc_idx  = 4'd14 - cnt[3:0];
        case (st)
            SOF, IDE, R0: field_bit_f = 1'b0;
            ID:           field_bit_f = id[id_idx];
            RTR:          field_bit_f = rtr;
            DLC:          field_bit_f = dlc[dlc_idx];
            DATA:         field_bit_f = data[data_idx];
            CRC:          field_bit_f = crc[crc_idx];
            default:      field_bit_f = 1'b1;
        endcase
    endfunction

    // DATA length in bits; DLC codes above 8 still mean 8 bytes.
    always_comb begin
        if (rtr_r || (dlc_r == 4'd0)) begin
            data_len_s = 7'd0;
        end else if (dlc_r[3]) begin
            data_len_s = 7'd64;
        end else begin
            data_len_s = {1'b0, dlc_r[2:0], 3'b000};
        end
    end

    // Last bit index of the current field and the field that follows it.
    always_comb begin
        last_idx_s = 7'd0;
        follow_s   = IDLE;
        case (state_r)
            SOF:         begin last_idx_s = 7'd0;  follow_s = ID;          end
            ID:          begin last_idx_s = 7'd10; follow_s = RTR;         end
            RTR:         begin last_idx_s = 7'd0;  follow_s = IDE;         end
            IDE:         begin last_idx_s = 7'd0;  follow_s = R0;          end
            R0:          begin last_idx_s = 7'd0;  follow_s = DLC;         end
            DLC:         begin
                last_idx_s = 7'd3;
                follow_s   = (data_len_s == 7'd0) ? CRC : DATA;
            end
            DATA:        begin last_idx_s = data_len_s - 7'd1; follow_s = CRC; end
            CRC:         begin last_idx_s = 7'd14; follow_s = STUFF_FLUSH; end
            STUFF_FLUSH: begin last_idx_s = 7'd0;  follow_s = CRC_DELIM;   end
            CRC_DELIM:   begin last_idx_s = 7'd0;  follow_s = ACK_SLOT;    end
            ACK_SLOT:    begin last_idx_s = 7'd0;  follow_s = ACK_DELIM;   end
            ACK_DELIM:   begin last_idx_s = 7'd0;  follow_s = EOF;         end
            EOF:         begin last_idx_s = 7'd6;  follow_s = IFS;         end
            IFS:         begin last_idx_s = 7'd2;  follow_s = IDLE;        end
            default:     begin last_idx_s = 7'd0;  follow_s = IDLE;        end
        endcase
    end

    // Handshake, CRC accumulation and the bit to present after this edge.
    // The first CRC bit is taken from crc_nxt_s so it already includes the
    // last header/data bit transferred on the same edge.
    always_comb begin
        xfer_s = valid_r & bs.ready;
        if (xfer_s && crc_zone_f(state_r)) begin
            crc_nxt_s = crc15_step_f(crc_r, bit_out_r);
        end else begin
            crc_nxt_s = crc_r;
        end
        if (xfer_s && (cnt_r == last_idx_s)) begin
            nxt_state_s = follow_s;
            nxt_cnt_s   = 7'd0;
        end else if (xfer_s) begin
            nxt_state_s = state_r;
            nxt_cnt_s   = cnt_r + 7'd1;
        end else begin
            nxt_state_s = state_r;
            nxt_cnt_s   = cnt_r;
        end
        nxt_bit_s = field_bit_f(nxt_state_s, nxt_cnt_s[5:0], crc_nxt_s,
                                id_r, rtr_r, dlc_r, data_r);
    end

    // Frame FSM with registered stream and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            cnt_r      <= 7'd0;
            crc_r      <= 15'd0;
            id_r       <= 11'd0;
            rtr_r      <= 1'b0;
            dlc_r      <= 4'd0;
            data_r     <= 64'd0;
            bit_out_r  <= 1'b1;
            valid_r    <= 1'b0;
            stuff_en_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (state_r == IDLE) begin
            done_r <= 1'b0;
            cnt_r  <= 7'd0;
            if (tx_req) begin
                id_r       <= tx_id;
                rtr_r      <= tx_rtr;
                dlc_r      <= tx_dlc;
                data_r     <= tx_data;
                crc_r      <= 15'd0;
                state_r    <= SOF;
                bit_out_r  <= 1'b0;
                valid_r    <= 1'b1;
                stuff_en_r <= 1'b1;
                busy_r     <= 1'b1;
            end else begin
                bit_out_r  <= 1'b1;
                valid_r    <= 1'b0;
                stuff_en_r <= 1'b0;
                busy_r     <= 1'b0;
            end
        end else if (tx_abort) begin
            // Abort wins over any transfer on this edge.
            state_r    <= IDLE;
            cnt_r      <= 7'd0;
            bit_out_r  <= 1'b1;
            valid_r    <= 1'b0;
            stuff_en_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else if (state_r == STUFF_FLUSH) begin
            // No bit offered; wait for the stuffer to drain a pending stuff bit.
            done_r <= 1'b0;
            if (bs.ready) begin
                state_r    <= CRC_DELIM;
                cnt_r      <= 7'd0;
                bit_out_r  <= 1'b1;
                valid_r    <= 1'b1;
                stuff_en_r <= 1'b0;
            end else begin
                state_r    <= STUFF_FLUSH;
                valid_r    <= 1'b0;
                stuff_en_r <= 1'b1;
            end
        end else begin
            state_r    <= nxt_state_s;
            cnt_r      <= nxt_cnt_s;
            crc_r      <= crc_nxt_s;
            bit_out_r  <= nxt_bit_s;
            valid_r    <= (nxt_state_s != IDLE) && (nxt_state_s != STUFF_FLUSH);
            stuff_en_r <= stuff_window_f(nxt_state_s);
            busy_r     <= (nxt_state_s != IDLE);
            done_r     <= (nxt_state_s == IDLE);
        end
    end

    assign bs.bit_out         = bit_out_r;
    assign bs.valid           = valid_r;
    assign bs.stuffing_enable = stuff_en_r;
    assign tx_busy            = busy_r;
    assign tx_done            = done_r;

endmodule
